// File: rtl/sign_narrow_if.sv
// Store-path bus between the register-file read port, sign_narrow and data memory.
// Signal names match the sign_narrow port list; the slave modport is the block's view.
interface sign_narrow_if;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic [1:0]  size_i;
    logic [1:0]  addr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [3:0]  be_o;
    logic        ovf_o;
    logic        misalign_o;
    logic [15:0] ovf_cnt_o;

    modport slave (
        input  valid_i, data_i, size_i, addr_i, ready_i,
        output ready_o, valid_o, data_o, be_o, ovf_o, misalign_o, ovf_cnt_o
    );

    modport master (
        output valid_i, data_i, size_i, addr_i, ready_i,
        input  ready_o, valid_o, data_o, be_o, ovf_o, misalign_o, ovf_cnt_o
    );
endinterface

// File: rtl/sign_narrow.sv
// Store-side narrowing and lane placement behind a 2-entry in-order buffer.
// Optional build macro SIGN_NARROW_SAT_EN: saturate instead of truncating on overflow.
module sign_narrow (
    input  logic         clk_i,
    input  logic         rst_i,
    sign_narrow_if.slave bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // High when the bits above the kept sign bit are not all copies of one value.
    function automatic logic sign_run_broken(input logic [24:0] hi);
        sign_run_broken = !((&hi) || !(|hi));
    endfunction

    logic [1:0]  state_r;
    logic [31:0] head_data_r, tail_data_r;
    logic [3:0]  head_be_r, tail_be_r;
    logic        head_ovf_r, tail_ovf_r;
    logic        head_mis_r, tail_mis_r;
    logic [15:0] cnt_r;

    logic        byte_ovf_s, half_ovf_s;
    logic [7:0]  byte_val_s;
    logic [15:0] half_val_s;
    logic [31:0] nxt_data_s;
    logic [3:0]  nxt_be_s;
    logic        nxt_ovf_s, nxt_mis_s;
    logic        acc_s, ret_s;

    assign acc_s = bus.valid_i && (state_r != ST_FULL);
    assign ret_s = (state_r != ST_EMPTY) && bus.ready_i;

    // Range check and narrowed value for byte and half accesses.
    always_comb begin
        byte_ovf_s = sign_run_broken(bus.data_i[31:7]);
        half_ovf_s = sign_run_broken({{8{bus.data_i[31]}}, bus.data_i[31:15]});
`ifdef SIGN_NARROW_SAT_EN
        if (byte_ovf_s) begin
            byte_val_s = bus.data_i[31] ? 8'h80 : 8'h7F;
        end else begin
            byte_val_s = bus.data_i[7:0];
        end
        if (half_ovf_s) begin
            half_val_s = bus.data_i[31] ? 16'h8000 : 16'h7FFF;
        end else begin
            half_val_s = bus.data_i[15:0];
        end
`else
        byte_val_s = bus.data_i[7:0];
        half_val_s = bus.data_i[15:0];
`endif
    end

    // Lane placement; a misaligned or illegal access carries no data and no overflow.
    always_comb begin
        nxt_data_s = 32'd0;
        nxt_be_s   = 4'd0;
        nxt_ovf_s  = 1'b0;
        nxt_mis_s  = 1'b0;
        case (bus.size_i)
            2'b00: begin
                nxt_data_s = {24'd0, byte_val_s} << {bus.addr_i, 3'b000};
                nxt_be_s   = 4'b0001 << bus.addr_i;
                nxt_ovf_s  = byte_ovf_s;
            end
            2'b01: begin
                if (bus.addr_i[0]) begin
                    nxt_mis_s = 1'b1;
                end else begin
                    nxt_data_s = {16'd0, half_val_s} << {bus.addr_i[1], 4'b0000};
                    nxt_be_s   = 4'b0011 << {bus.addr_i[1], 1'b0};
                    nxt_ovf_s  = half_ovf_s;
                end
            end
            2'b10: begin
                if (bus.addr_i != 2'b00) begin
                    nxt_mis_s = 1'b1;
                end else begin
                    nxt_data_s = bus.data_i;
                    nxt_be_s   = 4'b1111;
                end
            end
            default: begin
                nxt_mis_s = 1'b1;
            end
        endcase
    end

    // Buffer state and entries; the head entry drives the outputs and is zeroed when empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_EMPTY;
            head_data_r <= 32'd0;
            head_be_r   <= 4'd0;
            head_ovf_r  <= 1'b0;
            head_mis_r  <= 1'b0;
            tail_data_r <= 32'd0;
            tail_be_r   <= 4'd0;
            tail_ovf_r  <= 1'b0;
            tail_mis_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        head_data_r <= nxt_data_s;
                        head_be_r   <= nxt_be_s;
                        head_ovf_r  <= nxt_ovf_s;
                        head_mis_r  <= nxt_mis_s;
                        state_r     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_s && ret_s) begin
                        head_data_r <= nxt_data_s;
                        head_be_r   <= nxt_be_s;
                        head_ovf_r  <= nxt_ovf_s;
                        head_mis_r  <= nxt_mis_s;
                    end else if (acc_s) begin
                        tail_data_r <= nxt_data_s;
                        tail_be_r   <= nxt_be_s;
                        tail_ovf_r  <= nxt_ovf_s;
                        tail_mis_r  <= nxt_mis_s;
                        state_r     <= ST_FULL;
                    end else if (ret_s) begin
                        head_data_r <= 32'd0;
                        head_be_r   <= 4'd0;
                        head_ovf_r  <= 1'b0;
                        head_mis_r  <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (ret_s) begin
                        head_data_r <= tail_data_r;
                        head_be_r   <= tail_be_r;
                        head_ovf_r  <= tail_ovf_r;
                        head_mis_r  <= tail_mis_r;
                        tail_data_r <= 32'd0;
                        tail_be_r   <= 4'd0;
                        tail_ovf_r  <= 1'b0;
                        tail_mis_r  <= 1'b0;
                        state_r     <= ST_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    head_data_r <= 32'd0;
                    head_be_r   <= 4'd0;
                    head_ovf_r  <= 1'b0;
                    head_mis_r  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of overflowing items leaving the block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= 16'd0;
        end else if (ret_s && head_ovf_r && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign bus.valid_o    = (state_r != ST_EMPTY);
    assign bus.ready_o    = (state_r != ST_FULL);
    assign bus.data_o     = head_data_r;
    assign bus.be_o       = head_be_r;
    assign bus.ovf_o      = head_ovf_r;
    assign bus.misalign_o = head_mis_r;
    assign bus.ovf_cnt_o  = cnt_r;

endmodule

// File: tb/tb_sign_narrow.sv
// Directed bench for sign_narrow: lane placement, overflow, misalignment, backpressure,
// counter saturation and reset. Expected values are hand-computed for both builds.
module tb_sign_narrow;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    sign_narrow_if bus ();

    sign_narrow dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One item with ready_i=1; any previous item retires on the same edge.
    task automatic xfer(input string tag, input logic [31:0] d, input logic [1:0] s,
                        input logic [1:0] a, input logic [31:0] ed, input logic [3:0] ebe,
                        input logic eovf, input logic emis);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.size_i  = s;
        bus.addr_i  = a;
        tick();
        bus.valid_i = 1'b0;
        check({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd1);
        check({tag, "_data"}, bus.data_o, ed);
        check({tag, "_be"}, {28'd0, bus.be_o}, {28'd0, ebe});
        check({tag, "_ovf"}, {31'd0, bus.ovf_o}, {31'd0, eovf});
        check({tag, "_mis"}, {31'd0, bus.misalign_o}, {31'd0, emis});
        if (eovf) exp_cnt++;
    endtask

    initial begin
        logic [31:0] half_ovf_exp;
        logic [31:0] byte_neg_exp;
        int n;
`ifdef SIGN_NARROW_SAT_EN
        half_ovf_exp = 32'h00007FFF;
        byte_neg_exp = 32'h80000000;
`else
        half_ovf_exp = 32'h00002345;
        byte_neg_exp = 32'h7F000000;
`endif
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.data_i  = 32'd0;
        bus.size_i  = 2'b00;
        bus.addr_i  = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("rst_data", bus.data_o, 32'd0);
        check("rst_be", {28'd0, bus.be_o}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf_o}, 32'd0);
        check("rst_mis", {31'd0, bus.misalign_o}, 32'd0);
        check("rst_cnt", {16'd0, bus.ovf_cnt_o}, 32'd0);

        bus.ready_i = 1'b1;
        xfer("byte_ok", 32'hFFFFFF85, 2'b00, 2'b10, 32'h00850000, 4'b0100, 1'b0, 1'b0);
        tick();
        check("empty_valid", {31'd0, bus.valid_o}, 32'd0);
        check("empty_data", bus.data_o, 32'd0);

        xfer("half_ovf", 32'h00012345, 2'b01, 2'b00, half_ovf_exp, 4'b0011, 1'b1, 1'b0);
        tick();
        check("half_ovf_cnt", {16'd0, bus.ovf_cnt_o}, 32'd1);

        xfer("word_mis", 32'hDEADBEEF, 2'b10, 2'b01, 32'd0, 4'b0000, 1'b0, 1'b1);
        xfer("illegal", 32'h12345678, 2'b11, 2'b00, 32'd0, 4'b0000, 1'b0, 1'b1);
        xfer("half_mis", 32'hFFFF0000, 2'b01, 2'b11, 32'd0, 4'b0000, 1'b0, 1'b1);
        xfer("byte_neg", 32'hFFFFFF7F, 2'b00, 2'b11, byte_neg_exp, 4'b1000, 1'b1, 1'b0);
        xfer("half_hi", 32'hFFFF8001, 2'b01, 2'b10, 32'h80010000, 4'b1100, 1'b0, 1'b0);
        xfer("word_ok", 32'h80000000, 2'b10, 2'b00, 32'h80000000, 4'b1111, 1'b0, 1'b0);
        tick();
        check("seq_cnt", {16'd0, bus.ovf_cnt_o}, exp_cnt);

        // Backpressure: A and B fill the buffer, C waits for space.
        bus.ready_i = 1'b0;
        bus.size_i  = 2'b00;
        bus.valid_i = 1'b1;
        bus.data_i  = 32'h11;
        bus.addr_i  = 2'b00;
        tick();
        check("bp_ready1", {31'd0, bus.ready_o}, 32'd1);
        bus.data_i = 32'h22;
        bus.addr_i = 2'b01;
        tick();
        check("bp_full", {31'd0, bus.ready_o}, 32'd0);
        bus.data_i = 32'h33;
        bus.addr_i = 2'b10;
        tick();
        check("bp_hold_data", bus.data_o, 32'h00000011);
        check("bp_hold_be", {28'd0, bus.be_o}, 32'h1);
        bus.ready_i = 1'b1;
        tick();
        check("bp_b_data", bus.data_o, 32'h00002200);
        check("bp_b_ready", {31'd0, bus.ready_o}, 32'd1);
        tick();
        bus.valid_i = 1'b0;
        check("bp_c_data", bus.data_o, 32'h00330000);
        check("bp_c_be", {28'd0, bus.be_o}, 32'h4);
        tick();
        check("bp_drained", {31'd0, bus.valid_o}, 32'd0);

        // Counter saturation with back-to-back overflowing bytes.
        bus.data_i  = 32'h00000100;
        bus.size_i  = 2'b00;
        bus.addr_i  = 2'b00;
        n = 32'hFFFE - exp_cnt;
        bus.valid_i = 1'b1;
        repeat (n) tick();
        bus.valid_i = 1'b0;
        tick();
        check("cnt_fffe", {16'd0, bus.ovf_cnt_o}, 32'h0000FFFE);
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        tick();
        check("cnt_ffff", {16'd0, bus.ovf_cnt_o}, 32'h0000FFFF);
        bus.valid_i = 1'b1;
        repeat (4) tick();
        bus.valid_i = 1'b0;
        tick();
        check("cnt_hold", {16'd0, bus.ovf_cnt_o}, 32'h0000FFFF);

        // Reset with the buffer full; the accept during reset is dropped.
        bus.ready_i = 1'b0;
        bus.data_i  = 32'h5A;
        bus.valid_i = 1'b1;
        tick();
        tick();
        check("pre_rst_full", {31'd0, bus.ready_o}, 32'd0);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        check("mid_rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("mid_rst_cnt", {16'd0, bus.ovf_cnt_o}, 32'd0);
        check("mid_rst_data", bus.data_o, 32'd0);
        tick();
        check("mid_rst_dropped", {31'd0, bus.valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
